// File: rtl/cpu_step_pkg.sv
// Shared types and helpers for the CPU clock-enable scheduler.
package cpu_step_pkg;

  // Scheduler state; encoding is visible on state_o.
  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  // Cycles between enable pulses for a given run-rate selection.
  function automatic int unsigned rate_div(input logic [1:0] rate_sel,
                                           input int unsigned clk_hz);
    int unsigned div;
    case (rate_sel)
      2'd0:    div = clk_hz;
      2'd1:    div = clk_hz / 10;
      2'd2:    div = clk_hz / 1000;
      default: div = 1;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-count debouncer and
// a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic step_p
);

  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  logic             level_q;
  logic [DEB_W-1:0] stable_cnt;

  assign btn_s = sync_q[1];

  // Bring the raw button into the clk_in domain.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Level changes only after DEB_CYCLES consecutive differing samples; any
  // sample equal to the current level restarts the count.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      level_q    <= 1'b0;
      stable_cnt <= '0;
      step_p     <= 1'b0;
    end else begin
      step_p <= 1'b0;
      if (btn_s == level_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DEB_LAST) begin
        level_q    <= btn_s;
        stable_cnt <= '0;
        step_p     <= btn_s;
      end else begin
        stable_cnt <= stable_cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable scheduler for the pipelined CPU: free-run at a selectable
// rate, single-step from a button, halt, or breakpoint halt.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        sw_run,
  input  logic        btn_step,
  input  logic [1:0]  rate_sel,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic [1:0]  state_o,
  output logic [31:0] cycle_count
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [1:0]       run_sync_q;
  logic             run_s;
  logic             step_p;
  logic [1:0]       rate_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  state_t           state;

  assign run_s   = run_sync_q[1];
  assign state_o = state;

  // Bring the run switch into the clk_in domain.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      run_sync_q <= 2'b00;
    end else begin
      run_sync_q <= {run_sync_q[0], sw_run};
    end
  end

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk_in (clk_in),
    .reset  (reset),
    .btn_raw(btn_step),
    .step_p (step_p)
  );

  // Terminal tick count for the registered rate selection.
  always_comb begin
    div_m1 = CNT_W'(rate_div(rate_q, CLK_HZ) - 32'd1);
  end

  // Scheduler FSM with tick counter, enable pulse and pulse counter.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= HALT;
      cnt         <= '0;
      cpu_en      <= 1'b0;
      cycle_count <= 32'd0;
      rate_q      <= 2'd0;
    end else begin
      rate_q <= rate_sel;
      cpu_en <= 1'b0;
      cnt    <= '0;
      case (state)
        HALT: begin
          if (run_s) begin
            state <= RUN;
          end else if (step_p) begin
            state       <= STEP;
            cpu_en      <= 1'b1;
            cycle_count <= cycle_count + 32'd1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state <= BREAK;
          end else if (!run_s) begin
            state <= HALT;
          end else if (rate_sel != rate_q) begin
            cnt <= '0;
          end else if (cnt == div_m1) begin
            cpu_en      <= 1'b1;
            cycle_count <= cycle_count + 32'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STEP: begin
          state <= HALT;
        end
        BREAK: begin
          if (!run_s) begin
            state <= HALT;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl with a behavioural reference model.
module tb_cpu_step_ctrl;

  localparam int unsigned CLK_HZ = 10_000;
  localparam int unsigned DEB    = 4;

  logic        clk_in   = 1'b0;
  logic        reset    = 1'b1;
  logic        sw_run   = 1'b0;
  logic        btn_step = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic        halt_req = 1'b0;
  logic        cpu_en;
  logic [1:0]  state_o;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state (0 halt, 1 run, 2 step, 3 break)
  int          m_state;
  bit          m_en;
  int unsigned m_count;
  int unsigned m_phase;
  bit [1:0]    m_rate_q;
  bit          m_step_p;
  bit          m_level;
  bit          run_h[$];
  bit          btn_h[$];

  always #5 clk_in = ~clk_in;

  cpu_step_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .sw_run     (sw_run),
    .btn_step   (btn_step),
    .rate_sel   (rate_sel),
    .halt_req   (halt_req),
    .cpu_en     (cpu_en),
    .state_o    (state_o),
    .cycle_count(cycle_count)
  );

  function automatic int unsigned model_div(input bit [1:0] r);
    int unsigned hz_per_pulse;
    hz_per_pulse = (r == 2'd0) ? 1 : (r == 2'd1) ? 10 : (r == 2'd2) ? 1000 : CLK_HZ;
    return CLK_HZ / hz_per_pulse;
  endfunction

  task automatic model_reset();
    m_state = 0; m_en = 0; m_count = 0; m_phase = 0; m_rate_q = 0;
    m_step_p = 0; m_level = 0;
    run_h = {}; btn_h = {};
    for (int i = 0; i < 8; i++) begin
      run_h.push_back(1'b0);
      btn_h.push_back(1'b0);
    end
  endtask

  // One clock edge of the model; raw inputs reach the logic two edges late.
  task automatic model_step();
    bit rs, sp, all_diff, en_n;
    int nxt;
    int unsigned dv;
    rs = run_h[run_h.size() - 2];
    all_diff = 1'b1;
    for (int i = 0; i < int'(DEB); i++)
      if (btn_h[btn_h.size() - 2 - i] == m_level) all_diff = 1'b0;
    sp = m_step_p;
    m_step_p = all_diff && !m_level;
    if (all_diff) m_level = !m_level;
    dv = model_div(m_rate_q);
    en_n = 1'b0;
    nxt = m_state;
    case (m_state)
      0: if (rs) nxt = 1; else if (sp) begin nxt = 2; en_n = 1'b1; end
      1: begin
        if (halt_req) nxt = 3;
        else if (!rs) nxt = 0;
        else if (rate_sel != m_rate_q) m_phase = 0;
        else if (m_phase == dv - 1) begin en_n = 1'b1; m_phase = 0; end
        else m_phase++;
      end
      2: nxt = 0;
      default: if (!rs) nxt = 0;
    endcase
    if (nxt != 1) m_phase = 0;
    m_rate_q = rate_sel;
    m_en = en_n;
    m_count = m_count + (en_n ? 1 : 0);
    m_state = nxt;
    run_h.push_back(sw_run);   void'(run_h.pop_front());
    btn_h.push_back(btn_step); void'(btn_h.pop_front());
  endtask

  task automatic tick();
    @(posedge clk_in);
    if (reset) model_reset(); else model_step();
    @(negedge clk_in);
    cyc++;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) tick();
    checks++;
    if (cpu_en !== 1'b0 || state_o !== 2'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_values en=%b st=%0d cnt=%0d required 0/0/0", cpu_en, state_o, cycle_count);
    end
    reset = 1'b0;
    rate_sel = 2'd3; sw_run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (cpu_en !== m_en || state_o !== 2'(m_state) || cycle_count !== m_count) begin
        errors++; $display("FAIL reset_prerun cyc=%0d en=%b/%b st=%0d/%0d cnt=%0d/%0d", cyc, cpu_en, m_en, state_o, m_state, cycle_count, m_count);
      end
    end
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (cpu_en !== 1'b0 || state_o !== 2'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_immediate en=%b st=%0d cnt=%0d required 0/0/0", cpu_en, state_o, cycle_count);
    end
    sw_run = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cpu_en !== 1'b0 || state_o !== 2'd0 || cycle_count !== 32'd0) begin
        errors++; $display("FAIL reset_hold en=%b st=%0d cnt=%0d required 0/0/0", cpu_en, state_o, cycle_count);
      end
    end
  endtask

  task automatic test_run_rates();
    int c0, pulses, guard;
    rate_sel = 2'd2;
    repeat (3) tick();
    sw_run = 1'b1;
    guard = 0;
    while (state_o !== 2'd1 && guard < 10) begin tick(); guard++; end
    checks++;
    if (state_o !== 2'd1 || guard != 3) begin
      errors++; $display("FAIL run_entry state=%0d after %0d cycles required 1 after 3", state_o, guard);
    end
    c0 = cyc; pulses = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      checks++;
      if (cpu_en !== m_en || state_o !== 2'(m_state) || cycle_count !== m_count) begin
        errors++; $display("FAIL run_rate2 cyc=%0d en=%b/%b st=%0d/%0d cnt=%0d/%0d", cyc, cpu_en, m_en, state_o, m_state, cycle_count, m_count);
      end
      if (cpu_en === 1'b1) begin
        pulses++;
        checks++;
        if (cyc - c0 != pulses * 10) begin
          errors++; $display("FAIL pulse_spacing pulse %0d at offset %0d required %0d", pulses, cyc - c0, pulses * 10);
        end
      end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL rate2_pulses got %0d required 3", pulses); end
    rate_sel = 2'd3;
    tick();
    checks++;
    if (cpu_en !== 1'b0) begin errors++; $display("FAIL rate_change_dead en=%b required 0", cpu_en); end
    guard = 0;
    while (pulses < 50 && guard < 100) begin
      tick(); guard++;
      checks++;
      if (cpu_en !== 1'b1) begin
        errors++; $display("FAIL full_speed cyc=%0d en=%b required 1", cyc, cpu_en);
      end else pulses++;
    end
    checks++;
    if (cycle_count !== 32'd50) begin errors++; $display("FAIL count_50 got %0d required 50", cycle_count); end
    sw_run = 1'b0;
    repeat (4) tick();
    checks++;
    if (state_o !== 2'd0 || cpu_en !== 1'b0) begin
      errors++; $display("FAIL run_off state=%0d en=%b required 0/0", state_o, cpu_en);
    end
  endtask

  task automatic test_step_bounce();
    int pulses, steps, step_at;
    int unsigned base;
    base = m_count; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      tick();
      if (cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL bounce_pulses got %0d required 0", pulses); end
    btn_step = 1'b1; steps = 0; step_at = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (cpu_en !== m_en || state_o !== 2'(m_state) || cycle_count !== m_count) begin
        errors++; $display("FAIL step_model cyc=%0d en=%b/%b st=%0d/%0d cnt=%0d/%0d", cyc, cpu_en, m_en, state_o, m_state, cycle_count, m_count);
      end
      if (cpu_en === 1'b1) pulses++;
      if (state_o === 2'd2) begin steps++; step_at = i; end
      else if (state_o !== 2'd0) begin
        errors++; $display("FAIL step_state cyc=%0d state=%0d required 0 or 2", cyc, state_o);
      end
    end
    checks++;
    if (pulses != 1 || steps != 1 || step_at == 9) begin
      errors++; $display("FAIL step_once pulses=%0d step_cycles=%0d required 1/1 then halt", pulses, steps);
    end
    btn_step = 1'b0;
    repeat (10) tick();
    checks++;
    if (cycle_count !== base + 32'd1 || state_o !== 2'd0) begin
      errors++; $display("FAIL step_count got %0d st=%0d required %0d st=0", cycle_count, state_o, base + 1);
    end
  endtask

  task automatic test_breakpoint();
    int guard;
    rate_sel = 2'd3;
    repeat (2) tick();
    sw_run = 1'b1; guard = 0;
    while (state_o !== 2'd1 && guard < 10) begin tick(); guard++; end
    repeat (5) tick();
    checks++;
    if (cpu_en !== 1'b1) begin errors++; $display("FAIL brk_running en=%b required 1", cpu_en); end
    halt_req = 1'b1;
    tick();
    checks++;
    if (cpu_en !== 1'b0 || state_o !== 2'd3) begin
      errors++; $display("FAIL brk_enter en=%b st=%0d required 0/3", cpu_en, state_o);
    end
    halt_req = 1'b0;
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) btn_step = 1'b0;
      tick();
      checks++;
      if (cpu_en !== 1'b0 || state_o !== 2'd3) begin
        errors++; $display("FAIL brk_step_ignored cyc=%0d en=%b st=%0d required 0/3", cyc, cpu_en, state_o);
      end
    end
    sw_run = 1'b0;
    repeat (2) tick();
    checks++;
    if (state_o !== 2'd3) begin errors++; $display("FAIL brk_exit_early state=%0d required 3", state_o); end
    tick();
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL brk_exit state=%0d required 0", state_o); end
  endtask

  task automatic test_halt_vs_tick();
    int guard;
    rate_sel = 2'd2;
    repeat (2) tick();
    sw_run = 1'b1; guard = 0;
    while (state_o !== 2'd1 && guard < 10) begin tick(); guard++; end
    repeat (9) tick();
    halt_req = 1'b1;
    tick();
    checks++;
    if (cpu_en !== 1'b0 || state_o !== 2'd3 || cycle_count !== m_count) begin
      errors++; $display("FAIL halt_vs_tick en=%b st=%0d cnt=%0d required 0/3/%0d", cpu_en, state_o, cycle_count, m_count);
    end
    halt_req = 1'b0; sw_run = 1'b0;
    repeat (4) tick();
    checks++;
    if (state_o !== 2'd0) begin errors++; $display("FAIL halt_vs_tick_exit state=%0d required 0", state_o); end
  endtask

  task automatic test_run_step_same();
    int steps;
    btn_step = 1'b1;
    repeat (4) tick();
    sw_run = 1'b1; steps = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (state_o === 2'd2 || cpu_en !== 1'b0) begin
        steps++; errors++; $display("FAIL run_step_same cyc=%0d st=%0d en=%b required no step pulse", cyc, state_o, cpu_en);
      end
    end
    checks++;
    if (state_o !== 2'd1) begin errors++; $display("FAIL run_step_state state=%0d required 1", state_o); end
    sw_run = 1'b0; btn_step = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) sw_run = ~sw_run;
      if ($urandom_range(29) == 0) halt_req = ~halt_req;
      if ($urandom_range(149) == 0) rate_sel = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) btn_step = ~btn_step;
      tick();
      checks++;
      if (cpu_en !== m_en || state_o !== 2'(m_state) || cycle_count !== m_count) begin
        errors++; $display("FAIL random cyc=%0d en=%b/%b st=%0d/%0d cnt=%0d/%0d", cyc, cpu_en, m_en, state_o, m_state, cycle_count, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_rates();
    test_step_bounce();
    test_breakpoint();
    test_halt_vs_tick();
    test_run_step_same();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
